// File: rtl/pb_updown_counter.sv
// pb_updown_counter
// Bounded up/down counter driven by one-cycle push-button release pulses.
// After each accepted pulse a lockout window drops further requests so a
// glitchy release cannot double-step. Limits either saturate or wrap.

module pb_updown_counter #(
   parameter int WIDTH       = 4,
   parameter int MAX_VAL     = 9,
   parameter int INIT_VAL    = 0,
   parameter int WRAP        = 0,
   parameter int LOCKOUT_CYC = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_rel,
   input  logic             dn_rel,
   input  logic             clr,
   output logic [WIDTH-1:0] count,
   output logic             step,
   output logic             at_max,
   output logic             at_min,
   output logic             busy
);

   // Lockout counter must hold LOCKOUT_CYC; keep at least one bit when disabled.
   localparam int LW = (LOCKOUT_CYC > 0) ? $clog2(LOCKOUT_CYC + 1) : 1;

   localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] INITV = WIDTH'(INIT_VAL);
   localparam logic [LW-1:0]    LOCKV = LW'(LOCKOUT_CYC);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_LOCK = 1'b1;

   logic [WIDTH-1:0] r_count;
   logic             r_step;
   logic             r_atMax;
   logic             r_atMin;
   logic [0:0]       r_state;
   logic [LW-1:0]    r_lockCnt;

   logic [WIDTH-1:0] w_nextCount;
   logic             w_nextStep;
   logic [0:0]       w_nextState;
   logic [LW-1:0]    w_nextLock;

   // Next-state logic: clr wins, then lockout drops requests, then a
   // simultaneous up/down cancels, otherwise a single request moves the count.
   always_comb begin
      w_nextCount = r_count;
      w_nextStep  = 1'b0;
      w_nextState = r_state;
      w_nextLock  = r_lockCnt;
      if (clr) begin
         w_nextCount = INITV;
         w_nextStep  = (r_count != INITV);
         w_nextLock  = '0;
         w_nextState = S_IDLE;
      end else if (r_state == S_LOCK) begin
         w_nextLock = r_lockCnt - 1'b1;
         if (r_lockCnt <= LW'(1)) begin
            w_nextLock  = '0;
            w_nextState = S_IDLE;
         end
      end else if (up_rel ^ dn_rel) begin
         if (up_rel) begin
            // Limit check happens before the increment so the register never overflows.
            if (r_count >= MAXV) begin
               if (WRAP != 0) w_nextCount = '0;
            end else begin
               w_nextCount = r_count + 1'b1;
            end
         end else begin
            // Wrapping down from zero lands on MAX_VAL, not the all-ones value.
            if (r_count == '0) begin
               if (WRAP != 0) w_nextCount = MAXV;
            end else begin
               w_nextCount = r_count - 1'b1;
            end
         end
         w_nextStep = (w_nextCount != r_count);
         if (LOCKOUT_CYC > 0) begin
            w_nextLock  = LOCKV;
            w_nextState = S_LOCK;
         end
      end
   end

   // State and output registers; limit flags are computed from the next count
   // so they change on the same edge as count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count   <= INITV;
         r_step    <= 1'b0;
         r_atMax   <= (INITV == MAXV);
         r_atMin   <= (INITV == '0);
         r_state   <= S_IDLE;
         r_lockCnt <= '0;
      end else begin
         r_count   <= w_nextCount;
         r_step    <= w_nextStep;
         r_atMax   <= (w_nextCount == MAXV);
         r_atMin   <= (w_nextCount == '0);
         r_state   <= w_nextState;
         r_lockCnt <= w_nextLock;
      end
   end

   assign count  = r_count;
   assign step   = r_step;
   assign at_max = r_atMax;
   assign at_min = r_atMin;
   assign busy   = (r_state == S_LOCK);

endmodule

// File: tb/tb_pb_updown_counter.sv
// tb_pb_updown_counter
// Directed bench driving a saturating and a wrapping counter with the same
// pulse sequence and comparing both against hand-computed values.

module tb_pb_updown_counter;

   logic       clk;
   logic       rst;
   logic       upRel;
   logic       dnRel;
   logic       clr;

   logic [3:0] satCount;
   logic       satStep;
   logic       satAtMax;
   logic       satAtMin;
   logic       satBusy;

   logic [3:0] wrapCount;
   logic       wrapStep;
   logic       wrapAtMax;
   logic       wrapAtMin;
   logic       wrapBusy;

   int checksTotal  = 0;
   int checksPassed = 0;

   pb_updown_counter #(
      .WIDTH(4), .MAX_VAL(9), .INIT_VAL(0), .WRAP(0), .LOCKOUT_CYC(3)
   ) dutSat (
      .clk(clk), .rst(rst), .up_rel(upRel), .dn_rel(dnRel), .clr(clr),
      .count(satCount), .step(satStep), .at_max(satAtMax),
      .at_min(satAtMin), .busy(satBusy)
   );

   pb_updown_counter #(
      .WIDTH(4), .MAX_VAL(9), .INIT_VAL(0), .WRAP(1), .LOCKOUT_CYC(3)
   ) dutWrap (
      .clk(clk), .rst(rst), .up_rel(upRel), .dn_rel(dnRel), .clr(clr),
      .count(wrapCount), .step(wrapStep), .at_max(wrapAtMax),
      .at_min(wrapAtMin), .busy(wrapBusy)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checksTotal++;
      if (observed === expected) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drive one cycle of requests at the falling edge, leave them in place
   // across the rising edge, then drop them just after it.
   task automatic applyStimulus(input logic up, input logic dn, input logic cl);
      @(negedge clk);
      upRel = up;
      dnRel = dn;
      clr   = cl;
      @(posedge clk);
      #1;
      upRel = 1'b0;
      dnRel = 1'b0;
      clr   = 1'b0;
   endtask

   // Idle cycles, ending just after a rising edge.
   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Accepted increment followed by the full lockout window.
   task automatic stepUp();
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitCycles(3);
   endtask

   // Main directed sequence
   initial begin
      rst   = 1'b1;
      upRel = 1'b0;
      dnRel = 1'b0;
      clr   = 1'b0;

      #2;
      checkOutput("rstCount",  satCount,  0);
      checkOutput("rstStep",   satStep,   0);
      checkOutput("rstBusy",   satBusy,   0);
      checkOutput("rstAtMax",  satAtMax,  0);
      checkOutput("rstAtMin",  satAtMin,  1);
      #10 rst = 1'b0;

      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t1Count", satCount, 1);
      checkOutput("t1Step",  satStep,  1);
      checkOutput("t1Busy",  satBusy,  1);
      checkOutput("t1AtMin", satAtMin, 0);
      waitCycles(1);
      checkOutput("t1StepLow", satStep, 0);
      checkOutput("t1Busy2",   satBusy, 1);
      waitCycles(1);
      checkOutput("t1Busy3",   satBusy, 1);
      waitCycles(1);
      checkOutput("t1BusyEnd", satBusy, 0);

      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("clrCount", satCount, 0);
      checkOutput("clrStep",  satStep,  1);

      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t2Count", satCount, 2);
      checkOutput("t2WrapCount", wrapCount, 2);
      checkOutput("t2Busy",  satBusy,  0);

      repeat (3) stepUp();
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("t5Count", satCount, 5);
      checkOutput("t5Step",  satStep,  0);
      checkOutput("t5Busy",  satBusy,  0);

      repeat (4) stepUp();
      checkOutput("t3PreCount", satCount, 9);
      checkOutput("t3PreAtMax", satAtMax, 1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t3Count", satCount, 9);
      checkOutput("t3Step",  satStep,  0);
      checkOutput("t3AtMax", satAtMax, 1);
      checkOutput("t3Busy",  satBusy,  1);
      checkOutput("t4Count", wrapCount, 0);
      checkOutput("t4Step",  wrapStep,  1);
      checkOutput("t4AtMin", wrapAtMin, 1);
      checkOutput("t4AtMax", wrapAtMax, 0);
      waitCycles(3);

      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("dnSatCount",  satCount,  8);
      checkOutput("dnSatStep",   satStep,   1);
      checkOutput("t4DnCount",   wrapCount, 9);
      checkOutput("t4DnAtMax",   wrapAtMax, 1);
      waitCycles(3);

      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("t6PreCount", satCount, 7);
      checkOutput("t6PreBusy",  satBusy,  1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("t6Count", satCount, 0);
      checkOutput("t6Busy",  satBusy,  0);
      checkOutput("t6Step",  satStep,  1);
      checkOutput("t6AtMin", satAtMin, 1);
      checkOutput("t6WrapCount", wrapCount, 0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t6Accept", satCount, 1);
      checkOutput("t6AccBusy", satBusy, 1);

      #2 rst = 1'b1;
      #1;
      checkOutput("midRstCount", satCount, 0);
      checkOutput("midRstBusy",  satBusy,  0);
      checkOutput("midRstStep",  satStep,  0);
      checkOutput("midRstAtMin", satAtMin, 1);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("postRstCount", satCount, 1);
      checkOutput("postRstStep",  satStep,  1);
      waitCycles(3);

      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("toZeroCount", satCount, 0);
      waitCycles(3);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("satMinCount", satCount, 0);
      checkOutput("satMinStep",  satStep,  0);
      checkOutput("satMinBusy",  satBusy,  1);
      checkOutput("wrapDnCount", wrapCount, 9);
      checkOutput("wrapDnStep",  wrapStep,  1);
      checkOutput("wrapDnAtMax", wrapAtMax, 1);

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
